// File: rtl/block_ram_write_arbiter.sv
// Round-robin arbiter sharing one block RAM write port among several writers.
// Optional per-requester grant counters: define RAM_ARB_GRANT_COUNT_EN.
module block_ram_write_arbiter #(
  parameter int NumRequesters = 4,
  parameter int DataWidth     = 8,
  parameter int AddressWidth  = 10
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
`ifdef RAM_ARB_GRANT_COUNT_EN
  input  logic [$clog2(NumRequesters)-1:0]      Stat_select,
  input  logic                                  Stat_clear,
  output logic [15:0]                           Stat_count,
`endif
  input  logic [NumRequesters-1:0]              Req_valid,
  input  logic [NumRequesters*AddressWidth-1:0] Req_address,
  input  logic [NumRequesters*DataWidth-1:0]    Req_data,
  output logic [NumRequesters-1:0]              Req_grant,
  output logic [NumRequesters-1:0]              Req_done,
  output logic                                  Busy,
  output logic                                  RAM_clka,
  output logic                                  RAM_wea,
  output logic [AddressWidth-1:0]               RAM_addra,
  inout  wire  [DataWidth-1:0]                  RAM_data
);

  localparam int IdxW = $clog2(NumRequesters);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    WRITE,
    RELEASE
  } state_t;

  state_t                 state;
  logic [IdxW-1:0]        ptr;
  logic [IdxW-1:0]        idx;
  logic [DataWidth-1:0]   data_q;
  logic                   sel_found;
  logic [IdxW-1:0]        sel_idx;

  assign RAM_clka = Clock;
  assign Busy     = (state != IDLE);
  assign RAM_data = RAM_wea ? data_q : {DataWidth{1'bz}};

  // First active requester at or above the pointer, wrapping around.
  always_comb begin
    int s;
    s         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NumRequesters - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= NumRequesters) s = s - NumRequesters;
      if (Req_valid[s]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(s);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      Req_grant <= '0;
      Req_done  <= '0;
      RAM_wea   <= 1'b0;
      RAM_addra <= '0;
      data_q    <= '0;
    end else begin
      Req_done <= '0;
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            idx       <= sel_idx;
            Req_grant <= NumRequesters'(1) << sel_idx;
            state     <= LATCH;
          end
        end
        LATCH: begin
          RAM_addra <= Req_address[idx*AddressWidth +: AddressWidth];
          data_q    <= Req_data[idx*DataWidth +: DataWidth];
          RAM_wea   <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          RAM_wea   <= 1'b0;
          Req_grant <= '0;
          Req_done  <= NumRequesters'(1) << idx;
          ptr       <= (int'(idx) == NumRequesters - 1) ? '0 : idx + 1'b1;
          state     <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_GRANT_COUNT_EN
  logic [15:0] cnt [NumRequesters];

  // Clear beats a same-cycle increment; counters saturate at all-ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NumRequesters; i++) cnt[i] <= '0;
      Stat_count <= '0;
    end else begin
      if (Stat_clear) begin
        for (int i = 0; i < NumRequesters; i++) cnt[i] <= '0;
      end else if (state == RELEASE && cnt[idx] != 16'hFFFF) begin
        cnt[idx] <= cnt[idx] + 16'd1;
      end
      if (int'(Stat_select) < NumRequesters) Stat_count <= cnt[Stat_select];
      else Stat_count <= '0;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
